// File: rtl/tx_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_serial_pkg
//  Description : Shared definitions for the parametrised serial transmitter:
//                FSM state encoding, parity mode constants and the frame
//                length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_serial_pkg;

  // FSM states; the numeric values are exported on db_estado.
  typedef enum logic [1:0] {
    INICIAL   = 2'd0,
    CARREGA   = 2'd1,
    TRANSMITE = 2'd2,
    FINAL     = 2'd3
  } estado_t;

  // Parity modes
  localparam int PAR_NENHUMA = 0;
  localparam int PAR_IMPAR   = 1;
  localparam int PAR_PAR     = 2;

  // Bits per frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int data_bits,
                                   input int parity,
                                   input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NENHUMA) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// ============================================================================
//  Module      : contador_m
//  Description : Modulo-M up counter used as the baud tick generator.
//  Revision    : 1.0 - initial release
//  Ports       : clock   - system clock (rising edge)
//                zera_as - asynchronous clear, active high
//                zera_s  - synchronous clear, active high
//                conta   - count enable
//                fim     - high while the count equals M-1
// ============================================================================
module contador_m #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] r_q;

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      r_q <= '0;
    end else if (zera_s) begin
      r_q <= '0;
    end else if (conta) begin
      if (r_q == N'(M - 1)) begin
        r_q <= '0;
      end else begin
        r_q <= r_q + 1'b1;
      end
    end
  end

  assign fim = (r_q == N'(M - 1));

endmodule
`default_nettype wire

// File: rtl/tx_serial_generic.sv
`default_nettype none
// ============================================================================
//  Module      : tx_serial_generic
//  Description : Parametrised asynchronous serial transmitter with the
//                partida/pronto handshake. Frame = start bit, DATA_BITS data
//                bits LSB first, optional parity bit, STOP_BITS stop bits,
//                each bit lasting CLK_DIV clock cycles.
//  Option      : define TX_SERIAL_BUFFER_EN to add a one-entry holding
//                register for back-to-back frames.
//  Revision    : 1.0 - initial release
//  Ports       : clock        - system clock (rising edge)
//                reset        - asynchronous reset, active high
//                partida      - start request, level sampled
//                dados        - word to send
//                saida_serial - serial line, idle high
//                pronto       - one-cycle pulse at end of frame
//                ocupado      - frame in progress
//                buffer_cheio - holding register occupied
//                db_estado    - FSM state, debug
// ============================================================================
module tx_serial_generic
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS = 7,
  parameter int PARITY    = 2,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 buffer_cheio,
  output logic [3:0]           db_estado
);

  localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int BAUD_W    = $clog2(CLK_DIV);

  estado_t               r_estado;
  logic [DATA_BITS-1:0]  r_dado;
  logic [FRAME_LEN-1:0]  r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_saida;
  logic                  r_pronto;
  logic                  r_ocupado;

  logic                  w_fim;
  logic                  w_tick;
  logic                  w_zera_s;
  logic                  w_ultimo_bit;
  logic                  w_paridade;
  logic [FRAME_LEN-1:0]  w_frame;
  logic                  w_buf_cheio;
  logic [DATA_BITS-1:0]  w_buf_dado;

  // --------------------------------------------------------------------------
  // Baud tick: counter only runs in TRANSMITE, so bit 0 starts a full period
  // right after CARREGA.
  // --------------------------------------------------------------------------
  assign w_zera_s = (r_estado != TRANSMITE);

  contador_m #(
    .M (CLK_DIV),
    .N (BAUD_W)
  ) u_baud (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (w_zera_s),
    .conta   (1'b1),
    .fim     (w_fim)
  );

  assign w_tick       = w_fim && (r_estado == TRANSMITE);
  assign w_ultimo_bit = (r_bit_cnt == CNT_W'(FRAME_LEN - 1));

  // --------------------------------------------------------------------------
  // Frame assembly from the captured word
  // --------------------------------------------------------------------------
  assign w_paridade = (PARITY == PAR_IMPAR) ? ~(^r_dado) : (^r_dado);

  always_comb begin
    w_frame                = '1;          // stop bits and padding
    w_frame[0]             = 1'b0;        // start bit
    w_frame[DATA_BITS:1]   = r_dado;
    if (PARITY != PAR_NENHUMA) begin
      w_frame[DATA_BITS+1] = w_paridade;
    end
  end

  // --------------------------------------------------------------------------
  // Optional holding register
  // --------------------------------------------------------------------------
`ifdef TX_SERIAL_BUFFER_EN
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_buf_cheio;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf       <= '0;
      r_buf_cheio <= 1'b0;
    end else if (r_estado == FINAL && r_buf_cheio) begin
      // The FSM takes the word on this same edge.
      r_buf_cheio <= 1'b0;
    end else if ((r_estado == CARREGA || r_estado == TRANSMITE) &&
                 partida && !r_buf_cheio) begin
      r_buf       <= dados;
      r_buf_cheio <= 1'b1;
    end
  end

  assign w_buf_cheio = r_buf_cheio;
  assign w_buf_dado  = r_buf;
`else
  assign w_buf_cheio = 1'b0;
  assign w_buf_dado  = '0;
`endif

  // --------------------------------------------------------------------------
  // Main FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_dado    <= '0;
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_saida   <= 1'b1;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        INICIAL: begin
          if (partida) begin
            r_dado    <= dados;
            r_ocupado <= 1'b1;
            r_estado  <= CARREGA;
          end
        end

        CARREGA: begin
          // Start bit goes straight to the line; the rest waits in r_shift.
          r_saida   <= w_frame[0];
          r_shift   <= {1'b1, w_frame[FRAME_LEN-1:1]};
          r_bit_cnt <= '0;
          r_estado  <= TRANSMITE;
        end

        TRANSMITE: begin
          if (w_tick) begin
            // After the last bit the shifted-in ones leave the line idle.
            r_saida <= r_shift[0];
            r_shift <= {1'b1, r_shift[FRAME_LEN-1:1]};
            if (w_ultimo_bit) begin
              r_ocupado <= 1'b0;
              r_pronto  <= 1'b1;
              r_estado  <= FINAL;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        FINAL: begin
          // A buffered word takes priority over a new external request.
          if (w_buf_cheio) begin
            r_dado    <= w_buf_dado;
            r_ocupado <= 1'b1;
            r_estado  <= CARREGA;
          end else if (partida) begin
            r_dado    <= dados;
            r_ocupado <= 1'b1;
            r_estado  <= CARREGA;
          end else begin
            r_estado  <= INICIAL;
          end
        end

        default: r_estado <= INICIAL;
      endcase
    end
  end

  assign saida_serial = r_saida;
  assign pronto       = r_pronto;
  assign ocupado      = r_ocupado;
  assign buffer_cheio = w_buf_cheio;
  assign db_estado    = {2'b00, r_estado};

endmodule
`default_nettype wire
